uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Controller that shares the single RS-232 UART transmitter between two byte producers: requester 0 (CPU memory-mapped TX register) and requester 1 (debug/echo path fed from the UART receiver). It arbitrates round-robin, latches the winning byte, sequences the transmitter core through a start/busy handshake, and enforces a programmable inter-frame gap. It sits between the CPU I/O decode and the UART TX serializer inside `top`, driving `RS232_Uart_TX` only indirectly.

## Interface
- `DATA_W`, 8, byte width of requester and TX data.
- `GAP_CYCLES`, 0, idle CLK cycles inserted after each frame completes (0 = no gap).
- `BUSY_TIMEOUT`, 15, max CLK cycles to wait for `TX_BUSY` to rise after `TX_START`; must be ≥1.
- `CLK`  in  1  system clock (100 MHz).
- `RST`  in  1  asynchronous, active-low reset.
- `REQ0_VALID`  in  1  requester 0 (CPU) has a byte.
- `REQ0_DATA`  in  DATA_W  requester 0 byte.
- `REQ0_READY`  out  1  requester 0 byte accepted this edge when high with VALID.
- `REQ1_VALID`  in  1  requester 1 (debug/echo) has a byte.
- `REQ1_DATA`  in  DATA_W  requester 1 byte.
- `REQ1_READY`  out  1  requester 1 accept.
- `TX_START`  out  1  one-cycle pulse to serializer.
- `TX_DATA`  out  DATA_W  byte to serializer, stable from START until frame end.
- `TX_BUSY`  in  1  serializer busy (high for whole frame).
- `GRANT`  out  2  one-hot owner of the current/last frame.
- `ACTIVE`  out  1  high in any state other than IDLE.
- `ERR`  out  1  sticky: busy-timeout occurred.
- `ERR_CLR`  in  1  synchronous clear of `ERR`.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if `TX_BUSY`=0 and any VALID, winner chosen round-robin: requester not granted last wins a tie; single requester always wins. Winner's READY driven high combinationally; other READY low. All READY low in every other state and when `TX_BUSY`=1.
- Accept edge (VALID&READY): `TX_DATA` ← winner data, `GRANT` ← winner one-hot, last-grant ← winner, → START.
- START: `TX_START`=1 (registered, exactly one cycle) → WAIT_BUSY; load timeout counter with `BUSY_TIMEOUT`.
- WAIT_BUSY: `TX_BUSY`=1 → WAIT_DONE; else decrement; counter reaches 0 with `TX_BUSY` still 0 → set `ERR`, → GAP (or IDLE if `GAP_CYCLES`=0).
- WAIT_DONE: `TX_BUSY`=0 → GAP, loading gap counter with `GAP_CYCLES`; → IDLE directly if `GAP_CYCLES`=0.
- GAP: decrement each cycle; → IDLE on the cycle counter reaches 1.
- `ERR`: set by timeout, cleared by `ERR_CLR`; set wins if both in same cycle.
- Requester data/VALID not sampled outside the accept edge; dropping VALID before accept is legal (no transfer).
- Counters sized to hold max(`BUSY_TIMEOUT`, `GAP_CYCLES`); no wrap.

## Timing
- Reset (`RST`=0, async): state IDLE, `TX_START`=0, `TX_DATA`=0, `GRANT`=2'b00, last-grant = requester 1 (so requester 0 wins first tie), `ACTIVE`=0, `ERR`=0, both READY=0 while in reset.
- Reset mid-frame: `TX_START` and `ACTIVE` drop immediately; no pending byte retained.
- Accept at edge N → `TX_START` high for cycle N..N+1 → WAIT_BUSY from edge N+1.
- Back-to-back, `GAP_CYCLES`=G: next accept possible no earlier than G+1 cycles after `TX_BUSY` falls (1 cycle if G=0).
- Simultaneous VALID on both: strict alternation 0,1,0,1… while both stay asserted.

## Test plan
- Reset then REQ0 only, byte 0x55, serializer model busy 10 cycles → REQ0_READY one cycle, TX_START single pulse next cycle, TX_DATA=0x55, GRANT=01, ACTIVE low again 1 cycle after busy falls.
- Both VALID continuously, REQ0=0xA1, REQ1=0xB2, four frames → TX_DATA order 0xA1,0xB2,0xA1,0xB2; GRANT 01,10,01,10.
- GAP_CYCLES=5, REQ1 held valid → second accept exactly 6 cycles after TX_BUSY falls.
- Serializer never raises TX_BUSY, BUSY_TIMEOUT=15 → ERR=1 after 15 cycles in WAIT_BUSY, returns to IDLE, next byte accepted; ERR_CLR pulse → ERR=0.
- RST low during WAIT_DONE → ACTIVE=0, GRANT=00 at once; after release REQ0 and REQ1 both valid → REQ0 wins.
- TX_BUSY=1 externally while IDLE with REQ0 valid → REQ0_READY stays 0 until busy falls.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX serializer between the
// CPU TX register (requester 0) and the debug/echo path (requester 1).
// Sequences the serializer via a START pulse and BUSY handshake, watches for a
// serializer that never goes busy, and inserts an optional inter-frame gap.
module uart_tx_arbiter #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned GAP_CYCLES   = 0,
   parameter int unsigned BUSY_TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ0_VALID,
   input  logic [DATA_W-1:0] REQ0_DATA,
   output logic              REQ0_READY,
   input  logic              REQ1_VALID,
   input  logic [DATA_W-1:0] REQ1_DATA,
   output logic              REQ1_READY,
   output logic              TX_START,
   output logic [DATA_W-1:0] TX_DATA,
   input  logic              TX_BUSY,
   output logic [1:0]        GRANT,
   output logic              ACTIVE,
   output logic              ERR,
   input  logic              ERR_CLR
);

   // Counter holds whichever is larger: the busy timeout or the gap length.
   localparam int unsigned CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam bit          GAP_EN  = (GAP_CYCLES != 0);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_WAIT_BUSY = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_GAP       = 3'd4;

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(BUSY_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_GAP     = CNT_W'(GAP_CYCLES);

   logic [2:0]        state_q,    state_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic              tx_start_q, tx_start_d;
   logic [DATA_W-1:0] tx_data_q,  tx_data_d;
   logic [1:0]        grant_q,    grant_d;
   logic              last_q,     last_d;     // 0: requester 0 granted last, 1: requester 1
   logic              active_q,   active_d;
   logic              err_q,      err_d;

   logic              can_accept_c;
   logic              pick1_c;
   logic              ready0_c;
   logic              ready1_c;
   logic              accept_c;
   logic              err_set_c;

   // Round-robin winner selection; readiness only in IDLE with an idle serializer.
   always_comb begin
      can_accept_c = RST && (state_q == S_IDLE) && !TX_BUSY;
      pick1_c      = REQ1_VALID && (!REQ0_VALID || !last_q);
      ready0_c     = can_accept_c && REQ0_VALID && !pick1_c;
      ready1_c     = can_accept_c && REQ1_VALID && pick1_c;
      accept_c     = ready0_c || ready1_c;
   end

   assign REQ0_READY = ready0_c;
   assign REQ1_READY = ready1_c;

   // Next-state and registered-output logic for the frame sequencer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      grant_d    = grant_q;
      last_d     = last_q;
      err_set_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               tx_data_d  = pick1_c ? REQ1_DATA : REQ0_DATA;
               grant_d    = pick1_c ? 2'b10 : 2'b01;
               last_d     = pick1_c;
               tx_start_d = 1'b1;
               state_d    = S_START;
            end
         end

         S_START: begin
            state_d = S_WAIT_BUSY;
            cnt_d   = CNT_TIMEOUT;
         end

         S_WAIT_BUSY: begin
            if (TX_BUSY) begin
               state_d = S_WAIT_DONE;
            end else if (cnt_q <= CNT_ONE) begin
               // Serializer never acknowledged the start: flag it and move on.
               err_set_c = 1'b1;
               if (GAP_EN) begin
                  state_d = S_GAP;
                  cnt_d   = CNT_GAP;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         S_WAIT_DONE: begin
            if (!TX_BUSY) begin
               if (GAP_EN) begin
                  state_d = S_GAP;
                  cnt_d   = CNT_GAP;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_GAP: begin
            if (cnt_q <= CNT_ONE) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Timeout set takes priority over a same-cycle clear.
      err_d    = err_set_c || (err_q && !ERR_CLR);
      active_d = (state_d != S_IDLE);
   end

   // State and output registers; last-grant resets to requester 1 so requester 0 wins the first tie.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         grant_q    <= 2'b00;
         last_q     <= 1'b1;
         active_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         active_q   <= active_d;
         err_q      <= err_d;
      end
   end

   assign TX_START = tx_start_q;
   assign TX_DATA  = tx_data_q;
   assign GRANT    = grant_q;
   assign ACTIVE   = active_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with no gap, one with a 5-cycle gap.
module tb_uart_tx_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       v0, v1, r0, r1, txs, busy, active, err, err_clr;
   logic [7:0] d0, d1, txd;
   logic [1:0] grant;

   logic       gv0, gv1, gr0, gr1, gtxs, gbusy, gactive, gerr, gerr_clr;
   logic [7:0] gd0, gd1, gtxd;
   logic [1:0] ggrant;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.DATA_W(8), .GAP_CYCLES(0), .BUSY_TIMEOUT(15)) dut (
      .CLK(clk), .RST(rst_n),
      .REQ0_VALID(v0), .REQ0_DATA(d0), .REQ0_READY(r0),
      .REQ1_VALID(v1), .REQ1_DATA(d1), .REQ1_READY(r1),
      .TX_START(txs), .TX_DATA(txd), .TX_BUSY(busy),
      .GRANT(grant), .ACTIVE(active), .ERR(err), .ERR_CLR(err_clr)
   );

   uart_tx_arbiter #(.DATA_W(8), .GAP_CYCLES(5), .BUSY_TIMEOUT(15)) dut_gap (
      .CLK(clk), .RST(rst_n),
      .REQ0_VALID(gv0), .REQ0_DATA(gd0), .REQ0_READY(gr0),
      .REQ1_VALID(gv1), .REQ1_DATA(gd1), .REQ1_READY(gr1),
      .TX_START(gtxs), .TX_DATA(gtxd), .TX_BUSY(gbusy),
      .GRANT(ggrant), .ACTIVE(gactive), .ERR(gerr), .ERR_CLR(gerr_clr)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; busy = 1'b0; err_clr = 1'b0;
      gv0 = 1'b0; gv1 = 1'b0; gbusy = 1'b0; gerr_clr = 1'b0;
      repeat (2) tick;
      rst_n = 1'b1;
      #1;
   endtask

   // Serializer stand-in: called right after an accept edge, runs a short frame back to IDLE.
   task automatic finish_frame;
      tick;
      busy = 1'b1;
      repeat (3) tick;
      busy = 1'b0;
      tick;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'h12; d1 = 8'h34; busy = 1'b0; err_clr = 1'b0;
      gv0 = 1'b0; gv1 = 1'b0; gd0 = 8'h00; gd1 = 8'h00; gbusy = 1'b0; gerr_clr = 1'b0;
      tick;
      checks++; if (txs !== 1'b0)    begin errors++; $display("FAIL reset_tx_start: got %b exp 0", txs); end
      checks++; if (txd !== 8'h00)   begin errors++; $display("FAIL reset_tx_data: got %h exp 00", txd); end
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b exp 00", grant); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b exp 0", active); end
      checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
      checks++; if (r0 !== 1'b0 || r1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b exp 00", r0, r1); end
      v0 = 1'b0; v1 = 1'b0;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_single;
      v0 = 1'b1; d0 = 8'h55;
      #1;
      checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL single_ready: got %b%b exp 10", r0, r1); end
      tick;
      v0 = 1'b0; d0 = 8'h00;
      #1;
      checks++; if (txs !== 1'b1)    begin errors++; $display("FAIL single_start: got %b exp 1", txs); end
      checks++; if (txd !== 8'h55)   begin errors++; $display("FAIL single_data: got %h exp 55", txd); end
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b exp 01", grant); end
      checks++; if (active !== 1'b1 || r0 !== 1'b0) begin errors++; $display("FAIL single_active: got active=%b ready0=%b exp 1/0", active, r0); end
      tick;
      checks++; if (txs !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b exp 0", txs); end
      busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick;
         checks++;
         if (active !== 1'b1 || txs !== 1'b0) begin
            errors++; $display("FAIL single_busy_%0d: got active=%b start=%b exp 1/0", i, active, txs);
         end
      end
      busy = 1'b0;
      #1;
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL single_active_at_fall: got %b exp 1", active); end
      tick;
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL single_idle_after: got %b exp 0", active); end
      checks++; if (grant !== 2'b01 || txd !== 8'h55) begin errors++; $display("FAIL single_hold: got grant=%b data=%h exp 01/55", grant, txd); end
   endtask

   task automatic test_round_robin;
      logic [7:0] exp_d;
      logic [1:0] exp_g;
      do_reset;
      v0 = 1'b1; d0 = 8'hA1; v1 = 1'b1; d1 = 8'hB2;
      #1;
      for (int i = 0; i < 4; i++) begin
         exp_d = (i % 2 == 0) ? 8'hA1 : 8'hB2;
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         checks++;
         if ({r1, r0} !== exp_g) begin errors++; $display("FAIL rr_ready_%0d: got %b exp %b", i, {r1, r0}, exp_g); end
         tick;
         checks++;
         if (txd !== exp_d || grant !== exp_g || txs !== 1'b1) begin
            errors++; $display("FAIL rr_frame_%0d: got data=%h grant=%b start=%b exp %h/%b/1", i, txd, grant, txs, exp_d, exp_g);
         end
         tick;
         busy = 1'b1;
         tick;
         checks++;
         if (r0 !== 1'b0 || r1 !== 1'b0) begin errors++; $display("FAIL rr_ready_busy_%0d: got %b%b exp 00", i, r0, r1); end
         repeat (2) tick;
         busy = 1'b0;
         tick;
      end
      v0 = 1'b0; v1 = 1'b0;
      #1;
   endtask

   task automatic test_gap;
      int n;
      gv1 = 1'b1; gd1 = 8'h3C;
      #1;
      checks++; if (gr1 !== 1'b1) begin errors++; $display("FAIL gap_ready_first: got %b exp 1", gr1); end
      tick;
      checks++;
      if (gtxs !== 1'b1 || gtxd !== 8'h3C || ggrant !== 2'b10) begin
         errors++; $display("FAIL gap_first_frame: got start=%b data=%h grant=%b exp 1/3c/10", gtxs, gtxd, ggrant);
      end
      tick;
      gbusy = 1'b1;
      repeat (4) tick;
      checks++; if (gr1 !== 1'b0) begin errors++; $display("FAIL gap_ready_busy: got %b exp 0", gr1); end
      gbusy = 1'b0;
      #1;
      n = 0;
      while (!gr1 && n < 20) begin
         tick;
         n++;
      end
      checks++; if (n != 6) begin errors++; $display("FAIL gap_spacing: got %0d cycles exp 6", n); end
      checks++; if (gactive !== 1'b0) begin errors++; $display("FAIL gap_idle: got %b exp 0", gactive); end
      tick;
      checks++;
      if (gtxs !== 1'b1 || ggrant !== 2'b10 || gtxd !== 8'h3C) begin
         errors++; $display("FAIL gap_second_accept: got start=%b grant=%b data=%h exp 1/10/3c", gtxs, ggrant, gtxd);
      end
      gv1 = 1'b0;
      #1;
   endtask

   task automatic test_timeout;
      v0 = 1'b1; d0 = 8'h77;
      #1;
      tick;
      v0 = 1'b0;
      checks++; if (txs !== 1'b1) begin errors++; $display("FAIL to_start: got %b exp 1", txs); end
      tick;
      for (int i = 0; i < 14; i++) begin
         tick;
         checks++;
         if (err !== 1'b0 || active !== 1'b1) begin
            errors++; $display("FAIL to_wait_%0d: got err=%b active=%b exp 0/1", i, err, active);
         end
      end
      tick;
      checks++; if (err !== 1'b1)    begin errors++; $display("FAIL to_err_set: got %b exp 1", err); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL to_idle: got %b exp 0", active); end
      v1 = 1'b1; d1 = 8'h9E;
      #1;
      checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL to_next_ready: got %b exp 1", r1); end
      tick;
      v1 = 1'b0;
      checks++;
      if (txd !== 8'h9E || grant !== 2'b10 || err !== 1'b1) begin
         errors++; $display("FAIL to_next_frame: got data=%h grant=%b err=%b exp 9e/10/1", txd, grant, err);
      end
      finish_frame;
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clr: got %b exp 0", err); end
      v0 = 1'b1; d0 = 8'h44;
      #1;
      tick;
      v0 = 1'b0; err_clr = 1'b1;
      tick;
      repeat (14) tick;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_clr_held: got %b exp 0", err); end
      tick;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_set_wins: got %b exp 1", err); end
      err_clr = 1'b0;
      tick;
      checks++; if (err !== 1'b1 || active !== 1'b0) begin errors++; $display("FAIL to_sticky: got err=%b active=%b exp 1/0", err, active); end
   endtask

   task automatic test_reset_mid;
      v0 = 1'b1; d0 = 8'h11;
      #1;
      tick;
      v0 = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (txs !== 1'b0 || active !== 1'b0 || grant !== 2'b00) begin
         errors++; $display("FAIL mid_rst_start: got start=%b active=%b grant=%b exp 0/0/00", txs, active, grant);
      end
      rst_n = 1'b1;
      #1;
      v0 = 1'b1; d0 = 8'h11;
      #1;
      tick;
      v0 = 1'b0;
      tick;
      busy = 1'b1;
      repeat (2) tick;
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL mid_in_frame: got %b exp 1", active); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (active !== 1'b0 || grant !== 2'b00 || txs !== 1'b0 || txd !== 8'h00) begin
         errors++; $display("FAIL mid_rst_done: got active=%b grant=%b start=%b data=%h exp 0/00/0/00", active, grant, txs, txd);
      end
      busy = 1'b0;
      repeat (2) tick;
      rst_n = 1'b1;
      v0 = 1'b1; d0 = 8'h11; v1 = 1'b1; d1 = 8'h22;
      #1;
      checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL mid_tie_ready: got %b%b exp 10", r0, r1); end
      tick;
      v0 = 1'b0; v1 = 1'b0;
      checks++;
      if (txd !== 8'h11 || grant !== 2'b01) begin
         errors++; $display("FAIL mid_tie_winner: got data=%h grant=%b exp 11/01", txd, grant);
      end
      finish_frame;
   endtask

   task automatic test_busy_idle;
      busy = 1'b1; v0 = 1'b1; d0 = 8'h5A;
      #1;
      checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL bi_ready_now: got %b exp 0", r0); end
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++;
         if (r0 !== 1'b0 || active !== 1'b0 || txs !== 1'b0) begin
            errors++; $display("FAIL bi_hold_%0d: got ready=%b active=%b start=%b exp 0/0/0", i, r0, active, txs);
         end
      end
      busy = 1'b0;
      #1;
      checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL bi_ready_after: got %b exp 1", r0); end
      tick;
      v0 = 1'b0;
      checks++;
      if (txs !== 1'b1 || txd !== 8'h5A || grant !== 2'b01) begin
         errors++; $display("FAIL bi_frame: got start=%b data=%h grant=%b exp 1/5a/01", txs, txd, grant);
      end
      finish_frame;
   endtask

   initial begin
      test_reset;
      test_single;
      test_round_robin;
      test_gap;
      test_timeout;
      test_reset_mid;
      test_busy_idle;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
